ps2_keypad: RTL and testbench

- Receives PS/2 set-2 scan codes from the board's USB-HID/PS/2 keyboard bridge.
- Validates each 11-bit frame and decodes make/break sequences for the arrow keys and space.
- Presents them as level "key held" signals that drive game_controller, in place of or alongside the pushbuttons.
- Sits on the on-board clock domain and is the input-side counterpart to the design's display outputs.

---
 rtl/ps2_defs_pkg.sv | 20 ++
 rtl/ps2_frame_rx.sv | 149 ++++++++++++++
 rtl/ps2_keypad.sv | 68 ++++++
 tb/tb_ps2_keypad.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs_pkg.sv
// Shared definitions for the PS/2 keypad receiver: frame FSM states and the
// set-2 scan codes the decoder recognises.
package ps2_defs;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_CEN   = 8'h29;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and de-glitches the keyboard lines, then
// assembles 11-bit frames, checking odd parity, stop bit and inter-bit timeout.
module ps2_frame_rx
  import ps2_defs::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       main_rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt, fall_edge, data_smp;
  logic [FW-1:0] flt_cnt;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  rx_state_e     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [7:0]    code_n;
  logic          valid_n, err_n;

  // Idle-high lines: synchronisers reset to 1 so release never looks like an edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock moves only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      filt      <= 1'b1;
      flt_cnt   <= '0;
      fall_edge <= 1'b0;
      data_smp  <= 1'b1;
    end else begin
      fall_edge <= 1'b0;
      if (clk_s2 != filt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          filt      <= clk_s2;
          flt_cnt   <= '0;
          fall_edge <= ~clk_s2;
          data_smp  <= dat_s2;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign timeout = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE || fall_edge || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    code_n    = scan_code;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    if (fall_edge) begin
      case (state)
        ST_IDLE: begin
          if (!data_smp) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end
        end
        ST_DATA: begin
          shift_n = {data_smp, shift[7:1]};
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
          else                 bit_cnt_n = bit_cnt + 1'b1;
        end
        ST_PARITY: begin
          par_n   = data_smp;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          if (data_smp && ((^shift) ^ par)) begin
            code_n  = shift;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_n = ST_IDLE;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      par        <= par_n;
      scan_code  <= code_n;
      scan_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keypad front end: receives scan codes and turns E0/F0 make/break
// sequences for the arrows and space into independent key-held levels.
module ps2_keypad
  import ps2_defs::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       main_rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       up_k,
  output logic       down_k,
  output logic       left_k,
  output logic       right_k,
  output logic       cen_k
);

  logic ext, brk;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .main_rst  (main_rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  // Prefix bytes only arm flags; the final byte of a sequence applies them and clears.
  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      ext     <= 1'b0;
      brk     <= 1'b0;
      up_k    <= 1'b0;
      down_k  <= 1'b0;
      left_k  <= 1'b0;
      right_k <= 1'b0;
      cen_k   <= 1'b0;
    end else if (scan_valid) begin
      if (scan_code == PS2_EXT) begin
        ext <= 1'b1;
      end else if (scan_code == PS2_BRK) begin
        brk <= 1'b1;
      end else begin
        if (ext  && scan_code == KEY_UP)    up_k    <= ~brk;
        if (ext  && scan_code == KEY_DOWN)  down_k  <= ~brk;
        if (ext  && scan_code == KEY_LEFT)  left_k  <= ~brk;
        if (ext  && scan_code == KEY_RIGHT) right_k <= ~brk;
        if (!ext && scan_code == KEY_CEN)   cen_k   <= ~brk;
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end else if (frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_keypad.sv
// Directed bench for ps2_keypad: stimulus pushes expected frame outcomes into a
// scoreboard queue; a monitor pops and compares on every scan_valid/frame_err.
module tb_ps2_keypad;

  localparam int FLT = 8;
  localparam int TO  = 600;
  localparam int H   = 40;   // ps2_clk half period in clk cycles

  logic       clk = 1'b0;
  logic       main_rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;
  logic       up_k, down_k, left_k, right_k, cen_k;

  ps2_keypad #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .main_rst  (main_rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err),
    .up_k      (up_k),
    .down_k    (down_k),
    .left_k    (left_k),
    .right_k   (right_k),
    .cen_k     (cen_k)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] code;
    int         lat;   // expected cycles from last pin falling edge, 0 = unchecked
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ref_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (main_rst && (scan_valid || frame_err)) begin
      check("valid_err_exclusive", 32'(scan_valid & frame_err), 32'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b code=%0h expected none",
                 scan_valid, frame_err, scan_code);
      end else begin
        e = q.pop_front();
        check("pulse_kind_err", 32'(frame_err), 32'(e.err));
        if (!e.err) check("scan_code", 32'(scan_code), 32'(e.code));
        if (e.lat > 0) begin
          d = cyc - ref_cyc;
          total++;
          if (d < e.lat - 1 || d > e.lat + 1) begin
            bad++;
            $display("FAIL latency: got %0d cycles expected %0d +-1", d, e.lat);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input bit err, input logic [7:0] code, input int lat);
    exp_t e;
    e.err  = err;
    e.code = code;
    e.lat  = lat;
    q.push_back(e);
  endtask

  // Drive the first nbits of a frame: start, 8 data LSB first, parity, stop.
  task automatic send_bits(input logic [7:0] code, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, bad_par ? ^code : ~^code, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(H);
      ps2_clk = 1'b0;
      ref_cyc = cyc;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic good(input logic [7:0] code);
    expect_frame(1'b0, code, FLT + 3);
    send_bits(code, 1'b0, 11);
    wait_cyc(40);
  endtask

  task automatic check_keys(input string name, input logic [4:0] exp);
    @(negedge clk);
    check(name, 32'({up_k, down_k, left_k, right_k, cen_k}), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(5);
    check("rst_scan_code", 32'(scan_code), 32'h00);
    check("rst_pulses", 32'({scan_valid, frame_err}), 32'd0);
    check_keys("rst_keys", 5'b00000);
    main_rst = 1'b1;
    wait_cyc(20);

    // Space make then break.
    good(8'h29);
    check_keys("cen_make", 5'b00001);
    good(8'hF0); good(8'h29);
    check_keys("cen_break", 5'b00000);

    // Two extended arrows held together, then release only up.
    good(8'hE0); good(8'h75);
    good(8'hE0); good(8'h6B);
    check_keys("up_left_held", 5'b10100);
    good(8'hE0); good(8'hF0); good(8'h75);
    check_keys("up_released", 5'b00100);

    // Non-extended keypad code matches nothing.
    good(8'h75);
    check_keys("keypad_75_ignored", 5'b00100);

    // Even parity frame: error only, scan_code retained.
    expect_frame(1'b1, 8'h00, FLT + 3);
    send_bits(8'h29, 1'b1, 11);
    wait_cyc(40);
    check("bad_parity_code_kept", 32'(scan_code), 32'h75);
    check_keys("bad_parity_keys", 5'b00100);

    // frame_err drops a pending E0, so the following 75 is non-extended.
    good(8'hE0);
    expect_frame(1'b1, 8'h00, 0);
    send_bits(8'h75, 1'b1, 11);
    wait_cyc(40);
    good(8'h75);
    check_keys("err_clears_ext", 5'b00100);

    // Timeout after 5 bits, then E0 74 decodes.
    expect_frame(1'b1, 8'h00, TO + FLT + 3);
    send_bits(8'h5A, 1'b0, 5);
    wait_cyc(TO + 100);
    good(8'hE0); good(8'h74);
    check_keys("right_after_timeout", 5'b00110);

    // Short ps2_clk glitches in IDLE are filtered out.
    for (int g = 0; g < 5; g++) begin
      ps2_data = g[0];
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
    check_keys("glitch_keys", 5'b00110);
    good(8'hE0); good(8'hF0); good(8'h6B);
    check_keys("left_break_after_glitch", 5'b00010);

    // Repeated E0 is idempotent; space joins the held set.
    good(8'hE0); good(8'hE0); good(8'h72);
    good(8'h29);
    check_keys("combo_held", 5'b01011);

    // Reset mid-frame with keys held.
    send_bits(8'h6B, 1'b0, 3);
    ps2_clk  = 1'b0;
    wait_cyc(2);
    main_rst = 1'b0;
    #1;
    check("midrst_keys", 32'({up_k, down_k, left_k, right_k, cen_k}), 32'd0);
    check("midrst_code", 32'(scan_code), 32'h00);
    wait_cyc(5);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    main_rst = 1'b1;
    wait_cyc(20);
    good(8'h29);
    check_keys("after_reset_frame", 5'b00001);

    wait_cyc(50);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
